// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU select codes, sequencer states, control word.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU select codes, shared with the ALU
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } seq_state_t;

  // long_op selects the slower adder latency
  typedef struct packed {
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic       legal;
    logic       long_op;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Opcode to control-word decode; purely combinational.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] op,
  output ctrl_t      ctrl
);

  // map opcode to ALU select and datapath mux controls; unknown opcodes stay illegal
  always_comb begin
    ctrl = '0;
    case (op)
      OP_LOADI: begin ctrl.aluop = ALU_FWD; ctrl.imm_sel = 1'b1; ctrl.legal = 1'b1; end
      OP_MOV:   begin ctrl.aluop = ALU_FWD; ctrl.legal = 1'b1; end
      OP_ADD:   begin ctrl.aluop = ALU_ADD; ctrl.legal = 1'b1; ctrl.long_op = 1'b1; end
      OP_SUB:   begin ctrl.aluop = ALU_ADD; ctrl.neg_sel = 1'b1; ctrl.legal = 1'b1; ctrl.long_op = 1'b1; end
      OP_AND:   begin ctrl.aluop = ALU_AND; ctrl.legal = 1'b1; end
      OP_OR:    begin ctrl.aluop = ALU_OR;  ctrl.legal = 1'b1; end
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one instruction, decodes it, holds the ALU
// controls for the ALU latency and strobes a single register write-back.
//
// state     | meaning
// ST_IDLE   | ready for a new instruction
// ST_DECODE | latched word being decoded, controls registered on exit
// ST_EXEC   | controls held while the ALU latency counter runs down
// ST_WB     | WRITEENABLE high for this one cycle
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned LOGIC_CYCLES = 1,
  parameter int unsigned ADD_CYCLES   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  ALUOP,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic [7:0]  IMMEDIATE,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        WRITEENABLE,
  output logic        ILLEGAL
);

  seq_state_t       state, next_state;
  ctrl_t            ctrl;
  logic [7:0]       op_q;
  logic [2:0]       dest_q;
  logic [2:0]       src1_q;
  logic [7:0]       imm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_load;
  logic             accept;
  logic             ready_d;
  logic             we_d;
  logic             illegal_d;

  // upper register-field bits carry no meaning for the 8-entry register file
  logic unused_instr_bits;
  assign unused_instr_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  assign accept   = (state == ST_IDLE) && INSTR_VALID && INSTR_READY;
  assign lat_load = ctrl.long_op ? CNT_W'(ADD_CYCLES) : CNT_W'(LOGIC_CYCLES);

  instr_decode u_decode (
    .op   (op_q),
    .ctrl (ctrl)
  );

  // state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  // next-state logic; counter at 1 means the last EXEC cycle
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_DECODE;
      ST_DECODE: next_state = ctrl.legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   if (cnt_q <= CNT_W'(1)) next_state = ST_WB;
      ST_WB:     next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // next values of the registered handshake/strobe outputs
  always_comb begin
    ready_d   = (next_state == ST_IDLE);
    we_d      = (next_state == ST_WB);
    illegal_d = (state == ST_DECODE) && !ctrl.legal;
  end

  // capture the instruction fields on accept; later INSTRUCTION changes are ignored
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      op_q   <= '0;
      dest_q <= '0;
      src1_q <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      op_q   <= INSTRUCTION[31:24];
      dest_q <= INSTRUCTION[18:16];
      src1_q <= INSTRUCTION[10:8];
      imm_q  <= INSTRUCTION[7:0];
    end
  end

  // latency down-counter: loaded on leaving DECODE, decremented through EXEC
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                                 cnt_q <= '0;
    else if (state == ST_DECODE && ctrl.legal)  cnt_q <= lat_load;
    else if (state == ST_EXEC && cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);
  end

  // registered outputs; controls load once in DECODE and hold through EXEC/WB
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      INSTR_READY <= 1'b1;
      WRITEENABLE <= 1'b0;
      ILLEGAL     <= 1'b0;
      ALUOP       <= ALU_FWD;
      IMM_SEL     <= 1'b0;
      NEG_SEL     <= 1'b0;
      READREG1    <= '0;
      READREG2    <= '0;
      WRITEREG    <= '0;
      IMMEDIATE   <= '0;
    end else begin
      INSTR_READY <= ready_d;
      WRITEENABLE <= we_d;
      ILLEGAL     <= illegal_d;
      if (state == ST_DECODE) begin
        ALUOP     <= ctrl.aluop;
        IMM_SEL   <= ctrl.imm_sel;
        NEG_SEL   <= ctrl.neg_sel;
        READREG1  <= src1_q;
        READREG2  <= imm_q[2:0];
        WRITEREG  <= dest_q;
        IMMEDIATE <= imm_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: single issues, illegal opcode,
// back-to-back stream and reset during execution.
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_VALID = 1'b0;
  logic        INSTR_READY;
  logic [2:0]  ALUOP, READREG1, READREG2, WRITEREG;
  logic [7:0]  IMMEDIATE;
  logic        IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL;

  int total = 0;
  int bad   = 0;

  instr_sequencer #(.LOGIC_CYCLES(1), .ADD_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALUOP(ALUOP), .READREG1(READREG1), .READREG2(READREG2),
    .WRITEREG(WRITEREG), .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
    .WRITEENABLE(WRITEENABLE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && INSTR_READY !== 1'b1; i++) @(negedge CLK);
    check_val("ready_wait", INSTR_READY, 1);
  endtask

  // issue one instruction and watch the following 7 cycles; lat = cycles from accept to WE
  task automatic run_op(input string nm, input logic [31:0] instr, input logic [2:0] e_aluop,
                        input logic e_imm, input logic e_neg, input logic [2:0] e_wr,
                        input logic [2:0] e_rr1, input logic [2:0] e_rr2, input int lat);
    int we_at, we_cnt, ill_cnt;
    logic rdy_low, stable;
    @(negedge CLK);
    wait_ready();
    INSTRUCTION = instr;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = ~instr;
    we_at = 0; we_cnt = 0; ill_cnt = 0; rdy_low = 1'b1; stable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge CLK);
      if (WRITEENABLE === 1'b1) begin
        we_cnt++;
        if (we_at == 0) begin
          we_at = i;
          check_val({nm, "_aluop"}, ALUOP, e_aluop);
          check_val({nm, "_imm_sel"}, IMM_SEL, e_imm);
          check_val({nm, "_neg_sel"}, NEG_SEL, e_neg);
          check_val({nm, "_writereg"}, WRITEREG, e_wr);
          check_val({nm, "_readreg1"}, READREG1, e_rr1);
          check_val({nm, "_readreg2"}, READREG2, e_rr2);
          check_val({nm, "_immediate"}, IMMEDIATE, instr[7:0]);
        end
      end
      if (ILLEGAL !== 1'b0) ill_cnt++;
      if (i <= lat && INSTR_READY !== 1'b0) rdy_low = 1'b0;
      if (i >= 2 && i <= lat && (ALUOP !== e_aluop || WRITEREG !== e_wr)) stable = 1'b0;
      if (i == lat + 1) check_val({nm, "_ready_back"}, INSTR_READY, 1);
    end
    check_val({nm, "_we_latency"}, we_at, lat);
    check_val({nm, "_we_count"}, we_cnt, 1);
    check_val({nm, "_no_illegal"}, ill_cnt, 0);
    check_val({nm, "_ready_low"}, rdy_low, 1);
    check_val({nm, "_stable"}, stable, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int we_cnt, ill_cnt, idx, cyc;
    int acc_cyc[4];
    int we_cyc[4];
    logic [31:0] stream[4];
    logic [2:0]  stream_op[4];
    logic        ops_ok;

    // reset values
    repeat (2) @(negedge CLK);
    check_val("rst_ready", INSTR_READY, 1);
    check_val("rst_aluop", ALUOP, 0);
    check_val("rst_addr", {READREG1, READREG2, WRITEREG}, 0);
    check_val("rst_imm", IMMEDIATE, 0);
    check_val("rst_flags", {IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL}, 0);
    RESET = 1'b1;

    // single issues: name, word, aluop, imm_sel, neg_sel, wr, rr1, rr2, latency
    run_op("loadi", 32'h0004002A, 3'b000, 1'b1, 1'b0, 3'd4, 3'd0, 3'd2, 3);
    run_op("add",   32'h02030102, 3'b001, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 4);
    run_op("sub",   32'h03050607, 3'b001, 1'b0, 1'b1, 3'd5, 3'd6, 3'd7, 4);
    run_op("and",   32'h040A0B0C, 3'b010, 1'b0, 1'b0, 3'd2, 3'd3, 3'd4, 3);
    run_op("or",    32'h05010203, 3'b011, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 3);
    run_op("mov",   32'h01070500, 3'b000, 1'b0, 1'b0, 3'd7, 3'd5, 3'd0, 3);

    // illegal opcode: pulse in the cycle after DECODE, ready returns with it
    @(negedge CLK);
    wait_ready();
    INSTRUCTION = 32'h09010203;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1 INSTR_VALID = 1'b0;
    @(negedge CLK);
    check_val("ill_decode_cycle", {ILLEGAL, INSTR_READY}, 2'b00);
    @(negedge CLK);
    check_val("ill_pulse", {ILLEGAL, INSTR_READY}, 2'b11);
    @(negedge CLK);
    check_val("ill_pulse_end", {ILLEGAL, INSTR_READY}, 2'b01);
    we_cnt = 0;
    repeat (4) begin
      @(negedge CLK);
      if (WRITEENABLE !== 1'b0) we_cnt++;
    end
    check_val("ill_no_we", we_cnt, 0);

    // back-to-back with VALID held: add, or, add, or
    stream[0] = 32'h02030102; stream_op[0] = 3'b001;
    stream[1] = 32'h05040506; stream_op[1] = 3'b011;
    stream[2] = 32'h02060001; stream_op[2] = 3'b001;
    stream[3] = 32'h05070203; stream_op[3] = 3'b011;
    idx = 0; we_cnt = 0; ill_cnt = 0; ops_ok = 1'b1;
    INSTR_VALID = 1'b1;
    for (cyc = 0; cyc < 40 && !(idx == 4 && we_cnt >= 4); cyc++) begin
      @(negedge CLK);
      if (WRITEENABLE === 1'b1) begin
        if (we_cnt < 4) begin
          we_cyc[we_cnt] = cyc;
          if (ALUOP !== stream_op[we_cnt]) ops_ok = 1'b0;
        end
        we_cnt++;
      end
      if (INSTR_READY === 1'b1) begin
        if (idx < 4) begin
          INSTRUCTION = stream[idx];
          acc_cyc[idx] = cyc;
          idx++;
        end else begin
          INSTR_VALID = 1'b0;
        end
      end
    end
    INSTR_VALID = 1'b0;
    check_val("b2b_issued", idx, 4);
    check_val("b2b_we_count", we_cnt, 4);
    check_val("b2b_aluop", ops_ok, 1);
    if (idx == 4 && we_cnt >= 4) begin
      check_val("b2b_gap_add", acc_cyc[1] - acc_cyc[0], 5);
      check_val("b2b_gap_or", acc_cyc[2] - acc_cyc[1], 4);
      check_val("b2b_gap_add2", acc_cyc[3] - acc_cyc[2], 5);
      check_val("b2b_lat_add", we_cyc[0] - acc_cyc[0], 4);
      check_val("b2b_lat_or", we_cyc[3] - acc_cyc[3], 3);
    end
    repeat (3) @(negedge CLK);

    // reset during EXEC of an add
    wait_ready();
    INSTRUCTION = 32'h02030102;
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    #1 INSTR_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst_mid_pre_aluop", ALUOP, 3'b001);
    RESET = 1'b0;
    #1;
    check_val("rst_mid_ready", INSTR_READY, 1);
    check_val("rst_mid_ctrl", {ALUOP, WRITEREG, READREG1, READREG2}, 0);
    check_val("rst_mid_flags", {IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL}, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    we_cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (WRITEENABLE !== 1'b0) we_cnt++;
    end
    check_val("rst_mid_no_we", we_cnt, 0);
    run_op("post_rst_or", 32'h05020304, 3'b011, 1'b0, 1'b0, 3'd2, 3'd3, 3'd4, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
